capture_ctrl: RTL and testbench

Write-side sequencer for the sample FIFO. It watches the ADC sample stream and waits for a level-crossing trigger once armed. It then pushes the trigger sample plus a programmed number of post-trigger samples into the FIFO through the write pointer's increment input. The block sits in the write clock domain between the ADC front end and the FIFO write port, and is the only driver of the FIFO write increment.

---
 rtl/capture_ctrl_if.sv | 32 +++
 rtl/capture_ctrl.sv | 165 ++++++++++++++++
 tb/tb_capture_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/capture_ctrl_if.sv
// ============================================================================
// capture_ctrl_if : sample stream in, FIFO write port out   | Rev 1.0
// ============================================================================
`default_nettype none

interface capture_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  sample_valid_i;
    logic [DATA_WIDTH-1:0] sample_i;
    logic                  fifo_full_i;
    logic                  wr_inc_o;
    logic [DATA_WIDTH-1:0] wr_data_o;

    modport master (
        input  sample_valid_i,
        input  sample_i,
        input  fifo_full_i,
        output wr_inc_o,
        output wr_data_o
    );

    modport slave (
        output sample_valid_i,
        output sample_i,
        output fifo_full_i,
        input  wr_inc_o,
        input  wr_data_o
    );
endinterface

`default_nettype wire

// File: rtl/capture_ctrl.sv
// ============================================================================
// capture_ctrl : armed level-crossing trigger, writes trigger + post samples  | Rev 1.0
// ============================================================================
`default_nettype none

module capture_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 10
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_i,
    capture_ctrl_if.master             bus,
    input  wire logic                  arm_i,
    input  wire logic                  abort_i,
    input  wire logic [DATA_WIDTH-1:0] trig_level_i,
    input  wire logic                  trig_rising_i,
    input  wire logic [CNT_WIDTH-1:0]  post_len_i,
    output logic                       busy_o,
    output logic                       triggered_o,
    output logic                       done_o,
    output logic                       overflow_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t                state_q,      state_d;
    logic [DATA_WIDTH-1:0] level_q,      level_d;
    logic                  rising_q,     rising_d;
    logic [CNT_WIDTH-1:0]  len_q,        len_d;
    logic [DATA_WIDTH-1:0] prev_q,       prev_d;
    logic                  prev_valid_q, prev_valid_d;
    logic [CNT_WIDTH-1:0]  remaining_q,  remaining_d;
    logic                  pend_q,       pend_d;
    logic [DATA_WIDTH-1:0] wr_data_q,    wr_data_d;
    logic                  triggered_q,  triggered_d;
    logic                  done_q,       done_d;
    logic                  overflow_q,   overflow_d;

    logic w_sample_above;
    logic w_prev_above;
    logic w_trigger;

    assign w_sample_above = (bus.sample_i >= level_q);
    assign w_prev_above   = (prev_q >= level_q);
    assign w_trigger      = prev_valid_q &&
                            (rising_q ? (!w_prev_above &&  w_sample_above)
                                      : ( w_prev_above && !w_sample_above));

    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        rising_d     = rising_q;
        len_d        = len_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        remaining_d  = remaining_q;
        pend_d       = 1'b0;
        wr_data_d    = wr_data_q;
        triggered_d  = triggered_q;
        done_d       = 1'b0;
        overflow_d   = overflow_q;

        // A presented write that meets a full FIFO is lost for good.
        if (pend_q && bus.fifo_full_i) begin
            overflow_d = 1'b1;
        end

        if (abort_i) begin
            state_d     = S_IDLE;
            triggered_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arm_i) begin
                        state_d      = S_ARMED;
                        level_d      = trig_level_i;
                        rising_d     = trig_rising_i;
                        len_d        = post_len_i;
                        prev_valid_d = 1'b0;
                        triggered_d  = 1'b0;
                        overflow_d   = 1'b0;
                    end
                end
                S_ARMED: begin
                    if (bus.sample_valid_i) begin
                        prev_d       = bus.sample_i;
                        prev_valid_d = 1'b1;
                        if (w_trigger) begin
                            pend_d      = 1'b1;
                            wr_data_d   = bus.sample_i;
                            triggered_d = 1'b1;
                            if (len_q == '0) begin
                                done_d  = 1'b1;
                                state_d = S_IDLE;
                            end else begin
                                remaining_d = len_q;
                                state_d     = S_CAPTURE;
                            end
                        end
                    end
                end
                S_CAPTURE: begin
                    // Counted even if later dropped, keeping the window time-aligned.
                    if (bus.sample_valid_i) begin
                        pend_d      = 1'b1;
                        wr_data_d   = bus.sample_i;
                        remaining_d = remaining_q - 1'b1;
                        if (remaining_q == CNT_WIDTH'(1)) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            level_q      <= '0;
            rising_q     <= 1'b0;
            len_q        <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            remaining_q  <= '0;
            pend_q       <= 1'b0;
            wr_data_q    <= '0;
            triggered_q  <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            rising_q     <= rising_d;
            len_q        <= len_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            remaining_q  <= remaining_d;
            pend_q       <= pend_d;
            wr_data_q    <= wr_data_d;
            triggered_q  <= triggered_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
        end
    end

    // Gated combinationally so the pointer never increments while full.
    assign bus.wr_inc_o  = pend_q & ~bus.fifo_full_i;
    assign bus.wr_data_o = wr_data_q;
    assign busy_o        = (state_q != S_IDLE);
    assign triggered_o   = triggered_q;
    assign done_o        = done_q;
    assign overflow_o    = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_capture_ctrl.sv
// ============================================================================
// tb_capture_ctrl : scoreboard bench for capture_ctrl  | Rev 1.0
// ============================================================================
`default_nettype none

module tb_capture_ctrl;

    localparam int DW = 8;
    localparam int CW = 10;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk_i;
    logic          rst_i;
    logic          arm_i;
    logic          abort_i;
    logic [DW-1:0] trig_level_i;
    logic          trig_rising_i;
    logic [CW-1:0] post_len_i;
    logic          busy_o;
    logic          triggered_o;
    logic          done_o;
    logic          overflow_o;

    capture_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    capture_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .bus          (bus.master),
        .arm_i        (arm_i),
        .abort_i      (abort_i),
        .trig_level_i (trig_level_i),
        .trig_rising_i(trig_rising_i),
        .post_len_i   (post_len_i),
        .busy_o       (busy_o),
        .triggered_o  (triggered_o),
        .done_o       (done_o),
        .overflow_o   (overflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int   n_cmp = 0;
    int   n_err = 0;
    int   writes_seen = 0;
    int   dones_seen  = 0;
    exp_t sb[$];
    exp_t mon_e;

    // Scoreboard: every presented write must match the oldest expected entry.
    always @(negedge clk_i) begin
        if (rst_i) begin
            if (done_o) dones_seen++;
            if (bus.wr_inc_o) begin
                writes_seen++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write: wr_data_o=%h done_o=%b, expected no write", bus.wr_data_o, done_o);
                end else begin
                    mon_e = sb.pop_front();
                    if ({bus.wr_data_o, done_o} !== {mon_e.data, mon_e.last}) begin
                        n_err++;
                        $display("FAIL write_data: got data=%h done=%b, expected data=%h done=%b",
                                 bus.wr_data_o, done_o, mon_e.data, mon_e.last);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic arm(input logic [DW-1:0] lvl, input logic rise, input logic [CW-1:0] len);
        arm_i = 1'b1; trig_level_i = lvl; trig_rising_i = rise; post_len_i = len;
        step();
        arm_i = 1'b0;
    endtask

    task automatic put(input logic [DW-1:0] s);
        bus.sample_valid_i = 1'b1; bus.sample_i = s;
        step();
        bus.sample_valid_i = 1'b0;
    endtask

    task automatic do_abort();
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b0; arm_i = 1'b0; abort_i = 1'b0; trig_level_i = '0; trig_rising_i = 1'b0;
        post_len_i = '0; bus.sample_valid_i = 1'b0; bus.sample_i = '0; bus.fifo_full_i = 1'b0;
        #22;
        n_cmp++;
        if ({bus.wr_inc_o, busy_o, triggered_o, done_o, overflow_o} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags: got %b expected 00000",
                              {bus.wr_inc_o, busy_o, triggered_o, done_o, overflow_o});
        end
        n_cmp++;
        if (bus.wr_data_o !== 8'h00) begin
            n_err++; $display("FAIL reset_data: got %h expected 00", bus.wr_data_o);
        end
        rst_i = 1'b1;
        step();
    endtask

    task automatic test_rising();
        int w0 = writes_seen, d0 = dones_seen;
        logic [DW-1:0] stim [7] = '{8'h10, 8'h70, 8'h90, 8'hA0, 8'hB0, 8'hC0, 8'hD0};
        arm(8'h80, 1'b1, 10'd3);
        n_cmp++;
        if ({busy_o, triggered_o} !== 2'b10) begin
            n_err++; $display("FAIL rise_armed: busy/trig got %b expected 10", {busy_o, triggered_o});
        end
        sb.push_back('{8'h90, 1'b0}); sb.push_back('{8'hA0, 1'b0});
        sb.push_back('{8'hB0, 1'b0}); sb.push_back('{8'hC0, 1'b1});
        for (int i = 0; i < 7; i++) put(stim[i]);
        step(); step();
        n_cmp++;
        if (writes_seen - w0 !== 4) begin
            n_err++; $display("FAIL rise_writes: got %0d expected 4", writes_seen - w0);
        end
        n_cmp++;
        if (dones_seen - d0 !== 1) begin
            n_err++; $display("FAIL rise_dones: got %0d expected 1", dones_seen - d0);
        end
        n_cmp++;
        if ({busy_o, triggered_o} !== 2'b01) begin
            n_err++; $display("FAIL rise_end: busy/trig got %b expected 01", {busy_o, triggered_o});
        end
    endtask

    task automatic test_falling_len0();
        int w0 = writes_seen, d0 = dones_seen;
        arm(8'h40, 1'b0, 10'd0);
        sb.push_back('{8'h30, 1'b1});
        put(8'h50);
        put(8'h30);
        n_cmp++;
        if ({bus.wr_inc_o, done_o, busy_o} !== 3'b110) begin
            n_err++; $display("FAIL fall_done: wr_inc/done/busy got %b expected 110",
                              {bus.wr_inc_o, done_o, busy_o});
        end
        step(); step();
        n_cmp++;
        if ((writes_seen - w0 !== 1) || (dones_seen - d0 !== 1)) begin
            n_err++; $display("FAIL fall_counts: writes=%0d dones=%0d expected 1 1",
                              writes_seen - w0, dones_seen - d0);
        end
    endtask

    task automatic test_first_sample_guard();
        int w0 = writes_seen;
        arm(8'h80, 1'b1, 10'd5);
        put(8'h90);
        put(8'h95);
        step(); step();
        n_cmp++;
        if ({busy_o, triggered_o} !== 2'b10 || writes_seen != w0) begin
            n_err++; $display("FAIL guard: busy/trig got %b writes=%0d expected 10 writes=0",
                              {busy_o, triggered_o}, writes_seen - w0);
        end
        do_abort();
    endtask

    task automatic test_full();
        int w0 = writes_seen, d0 = dones_seen;
        arm(8'h80, 1'b1, 10'd2);
        sb.push_back('{8'h90, 1'b0}); sb.push_back('{8'hB0, 1'b1});
        put(8'h70);
        put(8'h90);
        bus.sample_valid_i = 1'b1; bus.sample_i = 8'hA0;
        step();
        bus.fifo_full_i = 1'b1; bus.sample_i = 8'hB0;
        step();
        bus.fifo_full_i = 1'b0; bus.sample_valid_i = 1'b0;
        step(); step();
        n_cmp++;
        if (overflow_o !== 1'b1) begin
            n_err++; $display("FAIL full_overflow: got %b expected 1", overflow_o);
        end
        n_cmp++;
        if ((writes_seen - w0 !== 2) || (dones_seen - d0 !== 1)) begin
            n_err++; $display("FAIL full_counts: writes=%0d dones=%0d expected 2 1",
                              writes_seen - w0, dones_seen - d0);
        end
    endtask

    task automatic test_abort();
        int w0 = writes_seen, d0 = dones_seen;
        arm(8'h80, 1'b1, 10'd5);
        n_cmp++;
        if (overflow_o !== 1'b0) begin
            n_err++; $display("FAIL arm_clears_overflow: got %b expected 0", overflow_o);
        end
        sb.push_back('{8'h90, 1'b0}); sb.push_back('{8'hA0, 1'b0});
        put(8'h10);
        put(8'h90);
        put(8'hA0);
        n_cmp++;
        if (triggered_o !== 1'b1) begin
            n_err++; $display("FAIL abort_pre_trig: got %b expected 1", triggered_o);
        end
        do_abort();
        put(8'hB0);
        put(8'hC0);
        step();
        n_cmp++;
        if ({busy_o, triggered_o} !== 2'b00) begin
            n_err++; $display("FAIL abort_state: busy/trig got %b expected 00", {busy_o, triggered_o});
        end
        n_cmp++;
        if ((writes_seen - w0 !== 2) || (dones_seen != d0)) begin
            n_err++; $display("FAIL abort_counts: writes=%0d dones=%0d expected 2 0",
                              writes_seen - w0, dones_seen - d0);
        end
    endtask

    task automatic test_arm_abort_and_rearm();
        arm_i = 1'b1; abort_i = 1'b1;
        step();
        arm_i = 1'b0; abort_i = 1'b0;
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_err++; $display("FAIL arm_abort_same: busy got %b expected 0", busy_o);
        end
        arm(8'h40, 1'b0, 10'd0);
        sb.push_back('{8'h30, 1'b1});
        put(8'h50);
        put(8'h30);
        arm(8'h80, 1'b1, 10'd0);
        n_cmp++;
        if ({busy_o, triggered_o} !== 2'b10) begin
            n_err++; $display("FAIL rearm_in_done: busy/trig got %b expected 10", {busy_o, triggered_o});
        end
        do_abort();
    endtask

    task automatic test_async_reset();
        int w0 = writes_seen;
        arm(8'h80, 1'b1, 10'd4);
        put(8'h10);
        bus.sample_valid_i = 1'b1; bus.sample_i = 8'h90;
        @(posedge clk_i);
        #2;
        bus.sample_valid_i = 1'b0;
        rst_i = 1'b0;
        #1;
        n_cmp++;
        if ({bus.wr_inc_o, busy_o, triggered_o, done_o, overflow_o} !== 5'b0 || bus.wr_data_o !== 8'h00) begin
            n_err++; $display("FAIL async_reset: flags got %b data %h expected 00000 00",
                              {bus.wr_inc_o, busy_o, triggered_o, done_o, overflow_o}, bus.wr_data_o);
        end
        #1;
        rst_i = 1'b1;
        step(); step();
        n_cmp++;
        if (writes_seen != w0 || sb.size() != 0) begin
            n_err++; $display("FAIL async_reset_nowrite: writes=%0d pending_exp=%0d expected 0 0",
                              writes_seen - w0, sb.size());
        end
    endtask

    task automatic test_max_len_sparse();
        int w0 = writes_seen, d0 = dones_seen;
        logic [DW-1:0] v;
        arm(8'h80, 1'b1, 10'd1023);
        sb.push_back('{8'h90, 1'b0});
        put(8'h10);
        put(8'h90);
        for (int i = 0; i < 1023; i++) begin
            v = DW'(i * 3 + 1);
            sb.push_back('{v, (i == 1022)});
            put(v);
            step();
        end
        step(); step();
        n_cmp++;
        if (writes_seen - w0 !== 1024) begin
            n_err++; $display("FAIL maxlen_writes: got %0d expected 1024", writes_seen - w0);
        end
        n_cmp++;
        if ((dones_seen - d0 !== 1) || busy_o !== 1'b0) begin
            n_err++; $display("FAIL maxlen_done: dones=%0d busy=%b expected 1 0", dones_seen - d0, busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_rising();
        test_falling_len0();
        test_first_sample_guard();
        test_full();
        test_abort();
        test_arm_abort_and_rearm();
        test_async_reset();
        test_max_len_sparse();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL sb_drained: %0d expected writes never seen, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
